// File: rtl/coeff_load_sched.sv
// coeff_load_sched: round-robin arbiter that grants one coefficient source a whole
// burst at a time and turns its valid/ready stream into banked buffer writes.
module coeff_load_sched #(
    parameter int NREQ  = 4,
    parameter int NCOEF = 8,
    parameter int DW    = 16,
    parameter int AW    = $clog2(NREQ*NCOEF)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         in_valid,
    input  logic [NREQ*DW-1:0]      in_data,
    output logic [NREQ-1:0]         in_ready,
    output logic                    wr_en,
    output logic [AW-1:0]           wr_addr,
    output logic [DW-1:0]           wr_data,
    output logic [NREQ-1:0]         bank_done,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(NCOEF);
    localparam logic [CW-1:0] CNT_LAST = CW'(NCOEF - 1);
    localparam logic [AW-1:0] NCOEF_A  = AW'(NCOEF);
    localparam logic [GW-1:0] G_LAST   = GW'(NREQ - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   g_q, g_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [NREQ-1:0] bank_done_q, bank_done_d;
    logic [GW-1:0]   sel;
    logic            hs;
    int              idx;

    // Scan downward so the candidate closest to rr_ptr is the one left in sel.
    always_comb begin
        sel = rr_ptr_q;
        idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (in_valid[idx]) sel = GW'(idx);
        end
    end

    assign hs = (state_q == XFER) && in_valid[g_q];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        g_d         = g_q;
        cnt_d       = cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        bank_done_d = '0;
        case (state_q)
            IDLE: begin
                if (|in_valid) begin
                    g_d     = sel;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (hs) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = AW'(g_q) * NCOEF_A + AW'(cnt_q);
                    wr_data_d = in_data[g_q*DW +: DW];
                    if (cnt_q == CNT_LAST) begin
                        bank_done_d[g_q] = 1'b1;
                        state_d          = IDLE;
                        rr_ptr_d         = (g_q == G_LAST) ? '0 : g_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            g_q         <= '0;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            bank_done_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            g_q         <= g_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            bank_done_q <= bank_done_d;
        end
    end

    always_comb begin
        in_ready = '0;
        if (state_q == XFER) in_ready[g_q] = 1'b1;
    end

    assign busy      = (state_q == XFER);
    assign grant_id  = g_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign bank_done = bank_done_q;

endmodule

// File: tb/tb_coeff_load_sched.sv
// Bench for coeff_load_sched: directed bursts, expected writes queued at issue time
// and checked by an independent monitor.
module tb_coeff_load_sched;
    localparam int NREQ  = 4;
    localparam int NCOEF = 8;
    localparam int DW    = 16;
    localparam int AW    = $clog2(NREQ*NCOEF);
    localparam int GW    = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      in_valid;
    logic [NREQ*DW-1:0]   in_data;
    logic [NREQ-1:0]      in_ready;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic [NREQ-1:0]      bank_done;
    logic [GW-1:0]        grant_id;
    logic                 busy;

    coeff_load_sched #(.NREQ(NREQ), .NCOEF(NCOEF), .DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .bank_done(bank_done), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int done;
        int cyc;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   t1_chk = 0;

    int   src_base[NREQ];
    int   src_n[NREQ];
    bit   src_act[NREQ];
    int   pause_at[NREQ];
    int   pause_left[NREQ];
    logic [NREQ-1:0] hs_last;
    logic rst_last;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            in_valid[i] = src_act[i] && !(src_n[i] == pause_at[i] && pause_left[i] > 0);
            in_data[i*DW +: DW] = 16'(src_base[i] + src_n[i]);
        end
    endtask

    task automatic start_src(input int i, input int base, input int pat, input int pleft);
        src_act[i]    = 1'b1;
        src_n[i]      = 0;
        src_base[i]   = base;
        pause_at[i]   = pat;
        pause_left[i] = pleft;
    endtask

    task automatic push_burst(input int bank, input int base, input int n, input int start_cyc);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.addr = bank * NCOEF + k;
            e.data = (base + k) & 16'hFFFF;
            e.done = (k == NCOEF - 1) ? (1 << bank) : 0;
            e.cyc  = (start_cyc < 0) ? -1 : start_cyc + k;
            expq.push_back(e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (t1_chk) chk("t1_in_ready0", int'(in_ready[0]), int'(cyc >= 1 && cyc <= 8));
        hs_last  = in_valid & in_ready;
        rst_last = rst;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++) begin
            if (hs_last[i] && !rst_last) begin
                src_n[i]++;
                if (src_n[i] == NCOEF) src_act[i] = 1'b0;
            end else if (src_act[i] && src_n[i] == pause_at[i] && pause_left[i] > 0) begin
                pause_left[i]--;
            end
        end
        drive();
    endtask

    function automatic bit any_active();
        bit a = 0;
        for (int i = 0; i < NREQ; i++) a |= src_act[i];
        return a;
    endfunction

    task automatic run(input string nm, input int max_cyc);
        int c = 0;
        while ((expq.size() != 0 || any_active()) && c < max_cyc) begin
            tick();
            c++;
        end
        chk({nm, "_completed"}, int'(expq.size() == 0 && !any_active()), 1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_wr_en"}, int'(wr_en), 0);
        chk({nm, "_wr_addr"}, int'(wr_addr), 0);
        chk({nm, "_wr_data"}, int'(wr_data), 0);
        chk({nm, "_bank_done"}, int'(bank_done), 0);
        chk({nm, "_in_ready"}, int'(in_ready), 0);
        chk({nm, "_grant_id"}, int'(grant_id), 0);
        chk({nm, "_busy"}, int'(busy), 0);
    endtask

    // Monitor: consumes expected writes and checks protocol properties every cycle.
    logic [NREQ-1:0] mon_hs;
    logic            mon_rst;
    bit              mon_prev = 0;
    always @(negedge clk) begin
        exp_t e;
        if (mon_prev) chk("wr_en_follows_hs", int'(wr_en), int'((|mon_hs) && !mon_rst));
        mon_hs   = in_valid & in_ready;
        mon_rst  = rst;
        mon_prev = 1;
        chk("in_ready_decode", int'(in_ready), busy ? (1 << grant_id) : 0);
        if (wr_en) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none required (cycle %0d)",
                         wr_addr, wr_data, cyc);
            end else begin
                e = expq.pop_front();
                chk("wr_addr", int'(wr_addr), e.addr);
                chk("wr_data", int'(wr_data), e.data);
                chk("bank_done", int'(bank_done), e.done);
                if (e.cyc >= 0) chk("write_cycle", cyc, e.cyc);
            end
        end else if (bank_done != '0) begin
            checks++;
            errors++;
            $display("FAIL done_without_write: got bank_done 0x%0h required 0x0 (cycle %0d)",
                     bank_done, cyc);
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            src_act[i] = 0; src_n[i] = 0; src_base[i] = 0;
            pause_at[i] = -1; pause_left[i] = 0;
        end
        tick();
        tick();
        chk_all_zero("reset");

        // Single requester from reset
        start_src(0, 'h10, -1, 0);
        push_burst(0, 'h10, NCOEF, 2);
        rst = 1'b0;
        cyc = 0;
        t1_chk = 1;
        drive();
        run("t1", 40);
        t1_chk = 0;

        // All four requesting from reset
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) src_act[i] = 0;
        drive();
        tick();
        tick();
        for (int b = 0; b < NREQ; b++) begin
            start_src(b, 'h100 * (b + 1), -1, 0);
            push_burst(b, 'h100 * (b + 1), NCOEF, 2 + 9 * b);
        end
        rst = 1'b0;
        cyc = 0;
        drive();
        run("t2", 100);

        // Fairness: bank 1 alone, then 0 and 3 together
        start_src(1, 'h500, -1, 0);
        push_burst(1, 'h500, NCOEF, -1);
        drive();
        run("t3a", 40);
        start_src(0, 'h600, -1, 0);
        start_src(3, 'h700, -1, 0);
        push_burst(3, 'h700, NCOEF, -1);
        push_burst(0, 'h600, NCOEF, -1);
        drive();
        run("t3b", 60);

        // Stall: requester 2 pauses after its 4th coefficient; requester 0 waits
        start_src(2, 'h800, 4, 3);
        push_burst(2, 'h800, NCOEF, -1);
        drive();
        for (int c = 0; c < 50 && src_n[2] < 4; c++) tick();
        chk("t4_reached_gap", src_n[2], 4);
        start_src(0, 'h900, -1, 0);
        push_burst(0, 'h900, NCOEF, -1);
        drive();
        run("t4", 80);

        // Reset after 5 handshakes of requester 1
        start_src(1, 'hA00, -1, 0);
        push_burst(1, 'hA00, 5, -1);
        drive();
        for (int c = 0; c < 50 && src_n[1] < 5; c++) tick();
        chk("t5_reached_5", src_n[1], 5);
        rst = 1'b1;
        src_act[1] = 0;
        drive();
        tick();
        chk_all_zero("t5_after_rst");
        chk("t5_partial_drained", expq.size(), 0);
        rst = 1'b0;
        start_src(1, 'hB00, -1, 0);
        start_src(2, 'hC00, -1, 0);
        push_burst(1, 'hB00, NCOEF, -1);
        push_burst(2, 'hC00, NCOEF, -1);
        drive();
        run("t5", 60);

        for (int c = 0; c < 5; c++) tick();
        chk("final_queue_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coeff_load_sched.md
# coeff_load_sched

Round-robin scheduler that shares the single write port of the coefficient collection buffer between NREQ coefficient sources. Each source delivers one bank of NCOEF coefficients as a burst. The scheduler grants one source at a time for a whole burst and converts its valid/ready stream into buffer writes at bank-relative addresses. It pulses a per-bank done flag when the last coefficient of the burst is written.

## Interface
- NREQ, 4: number of requesters / coefficient banks (≥2)
- NCOEF, 8: coefficients per bank (≥2)
- DW, 16: coefficient width
- AW, $clog2(NREQ*NCOEF): write address width (derived)
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  NREQ  per-requester coefficient valid
- in_data  in  NREQ*DW  per-requester coefficient; requester i uses bits [i*DW +: DW]
- in_ready  out  NREQ  per-requester ready; at most one bit high
- wr_en  out  1  buffer write strobe (registered)
- wr_addr  out  AW  buffer write address = bank*NCOEF + index
- wr_data  out  DW  buffer write data
- bank_done  out  NREQ  one-cycle pulse, bit g, coincident with the last write of bank g
- grant_id  out  $clog2(NREQ)  index of the currently granted requester; valid while busy
- busy  out  1  high in XFER

## Operation
- State machine has two states: IDLE and XFER.
- Internal registers:
  - rr_ptr: round-robin start index.
  - g: granted index.
  - cnt: coefficient index, 0..NCOEF-1.
- IDLE:
  - in_ready = 0.
  - If any in_valid bit is set, select the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, …, NREQ-1, 0, …).
  - Register the selection as g, clear cnt, go to XFER.
  - If no bit is set, stay in IDLE.
- XFER:
  - in_ready[g] = 1; all other bits are 0.
  - A handshake is in_valid[g] & in_ready[g].
  - On a handshake, the next cycle has wr_en=1, wr_addr=g*NCOEF+cnt, wr_data=in_data[g]. Then cnt increments.
  - No handshake means a stall: no write, cnt and g hold.
- Burst end: a handshake with cnt==NCOEF-1 does the following.
  - Next cycle, bank_done[g]=1 alongside that last write.
  - State returns to IDLE.
  - rr_ptr = (g+1) mod NREQ.
- in_valid from non-granted requesters is ignored. They see in_ready=0 and must hold their data.
- A granted requester may drop in_valid mid-burst. It keeps the grant until all NCOEF coefficients have transferred; there is no timeout.
- Address arithmetic is unsigned and exact; no wrap is possible because g<NREQ and cnt<NCOEF.
- Reset:
  - Values: state=IDLE, rr_ptr=0, g=0, cnt=0, wr_en=0, wr_addr=0, wr_data=0, bank_done=0, in_ready=0, grant_id=0, busy=0.
  - Reset during XFER aborts the burst: no bank_done, and words already written are left in the buffer.
  - The cycle after reset deasserts behaves as IDLE with rr_ptr=0.

## Timing
- Arbitration takes one cycle. in_valid sampled in IDLE at cycle t gives busy/in_ready[g] high from cycle t+1.
- Write latency is one cycle from handshake to wr_en.
- Minimum burst is NCOEF XFER cycles, plus one IDLE cycle before the next grant. Peak rate is NCOEF writes per NCOEF+1 cycles.
- Last handshake in cycle t:
  - State is IDLE in t+1, with in_ready all 0.
  - The final write and the bank_done pulse occur in t+1.
  - Arbitration for the next burst happens in t+1, and the next grant is visible in t+2.
- in_ready, busy and grant_id are registered state decodes. They never depend combinationally on the in_valid of the same cycle.
- bank_done is high for exactly one cycle per completed burst.

## Test plan
- **Single requester:** NREQ=4, NCOEF=8. Requester 0 holds in_valid with data 0x10..0x17 starting cycle 0.
  - in_ready[0] is high for cycles 1–8.
  - wr_addr is 0..7 in cycles 2–9, with wr_data 0x10..0x17.
  - bank_done=4'b0001 in cycle 9 only.
- **All four requesting from reset:** all in_valid held.
  - Grants occur in order 0,1,2,3.
  - Each bank's addresses are contiguous: bank 3 writes 24..31.
  - Each burst starts 9 cycles after the previous one.
  - No two in_ready bits are ever high together.
- **Round-robin fairness:** after bank 1 completes (rr_ptr=2), assert requesters 0 and 3 simultaneously.
  - Requester 3 is granted first, then 0.
  - bank_done order is 0b1000 then 0b0001.
- **Stalls:** granted requester 2 drops in_valid for 3 cycles after its 4th coefficient.
  - No wr_en during the gap.
  - Writes resume at address 20.
  - Exactly 8 writes total; bank_done[2] comes with the write to address 23.
  - Another requester asserting in_valid during the gap is not granted until after completion.
- **Reset mid-burst:** assert rst for 1 cycle after 5 handshakes of requester 1.
  - All outputs are 0 the next cycle; there is no bank_done.
  - After release, with requesters 1 and 2 valid, requester 1 is granted (rr_ptr=0) and writes restart at address 8.
